// File: rtl/serial_mag_compare_ctrl_pkg.sv
// Shared constants for the digit-serial magnitude compare controller:
// state encoding, digit width and a width helper for the digit index.
package serial_mag_compare_ctrl_pkg;

   localparam int DIGIT_W = 2;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COMPARE = 2'd1,
      DONE    = 2'd2
   } state_t;

   // Bits needed to index n items, never less than one bit.
   function automatic int clog2_min1(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < n) r = i + 1;
      end
      if (r < 1) r = 1;
      return r;
   endfunction

endpackage

// File: rtl/serial_mag_compare_ctrl_comparator_two.sv
// The existing 2-bit unsigned magnitude comparator; exactly one output is high.
module comparatorTwo (
   input  logic [1:0] a,
   input  logic [1:0] b,
   output logic       gt,
   output logic       lt,
   output logic       eq
);

   assign gt = (a > b);
   assign lt = (a < b);
   assign eq = (a == b);

endmodule

// File: rtl/serial_mag_compare_ctrl.sv
// Digit-serial unsigned magnitude compare: walks one 2-bit comparator over the
// latched operands MSB digit first and stops at the first unequal digit.
//
// state   | meaning
// IDLE    | waiting for i_start; result flags hold the last outcome
// COMPARE | comparing digit d of the latched operands, one digit per clock
// DONE    | o_done pulse for one cycle, then back to IDLE
module serial_mag_compare_ctrl
   import serial_mag_compare_ctrl_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_start,
   input  logic [WIDTH-1:0] i_A,
   input  logic [WIDTH-1:0] i_B,
   output logic             o_busy,
   output logic             o_done,
   output logic             o_GT,
   output logic             o_LT,
   output logic             o_EQ
);

   localparam int NDIG = WIDTH / DIGIT_W;
   localparam int DW   = clog2_min1(NDIG);

   state_t                 state;
   logic [WIDTH-1:0]       a_reg;
   logic [WIDTH-1:0]       b_reg;
   logic [DW-1:0]          dig_idx;
   logic [DIGIT_W-1:0]     a_dig;
   logic [DIGIT_W-1:0]     b_dig;
   logic                   cmp_gt;
   logic                   cmp_lt;
   logic                   cmp_eq;

   always_comb begin
      a_dig = '0;
      b_dig = '0;
      for (int i = 0; i < NDIG; i++) begin
         if (dig_idx == DW'(i)) begin
            a_dig = a_reg[i*DIGIT_W +: DIGIT_W];
            b_dig = b_reg[i*DIGIT_W +: DIGIT_W];
         end
      end
   end

   comparatorTwo u_cmp (
      .a  (a_dig),
      .b  (b_dig),
      .gt (cmp_gt),
      .lt (cmp_lt),
      .eq (cmp_eq)
   );

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state   <= IDLE;
         a_reg   <= '0;
         b_reg   <= '0;
         dig_idx <= '0;
         o_busy  <= 1'b0;
         o_done  <= 1'b0;
         o_GT    <= 1'b0;
         o_LT    <= 1'b0;
         o_EQ    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               o_done <= 1'b0;
               if (i_start) begin
                  a_reg   <= i_A;
                  b_reg   <= i_B;
                  dig_idx <= DW'(NDIG - 1);
                  o_GT    <= 1'b0;
                  o_LT    <= 1'b0;
                  o_EQ    <= 1'b0;
                  o_busy  <= 1'b1;
                  state   <= COMPARE;
               end
            end
            COMPARE: begin
               // digit 0 always leaves COMPARE, so dig_idx never underflows
               if (cmp_gt) begin
                  o_GT   <= 1'b1;
                  o_done <= 1'b1;
                  state  <= DONE;
               end else if (cmp_lt) begin
                  o_LT   <= 1'b1;
                  o_done <= 1'b1;
                  state  <= DONE;
               end else if (cmp_eq && (dig_idx == '0)) begin
                  o_EQ   <= 1'b1;
                  o_done <= 1'b1;
                  state  <= DONE;
               end else begin
                  dig_idx <= dig_idx - 1'b1;
               end
            end
            DONE: begin
               o_done <= 1'b0;
               o_busy <= 1'b0;
               state  <= IDLE;
            end
            default: begin
               o_done <= 1'b0;
               o_busy <= 1'b0;
               state  <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_mag_compare_ctrl.sv
// Directed bench for serial_mag_compare_ctrl at WIDTH=8.
module tb_serial_mag_compare_ctrl;

   logic       i_clk = 1'b0;
   logic       i_rst = 1'b1;
   logic       i_start = 1'b0;
   logic [7:0] i_A = '0;
   logic [7:0] i_B = '0;
   logic       o_busy, o_done, o_GT, o_LT, o_EQ;

   int total = 0;
   int bad   = 0;

   serial_mag_compare_ctrl #(.WIDTH(8)) dut (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_start (i_start),
      .i_A     (i_A),
      .i_B     (i_B),
      .o_busy  (o_busy),
      .o_done  (o_done),
      .o_GT    (o_GT),
      .o_LT    (o_LT),
      .o_EQ    (o_EQ)
   );

   always #5 i_clk = ~i_clk;

   task automatic step();
      @(posedge i_clk);
      #1;
   endtask

   task automatic test_reset();
      i_rst = 1'b1;
      step();
      step();
      total++;
      if ({o_busy, o_done, o_GT, o_LT, o_EQ} !== 5'b00000) begin
         bad++;
         $display("FAIL reset_outputs got=%b want=00000", {o_busy, o_done, o_GT, o_LT, o_EQ});
      end
      i_rst = 1'b0;
      step();
      total++;
      if ({o_busy, o_done} !== 2'b00) begin
         bad++;
         $display("FAIL reset_idle got=%b want=00", {o_busy, o_done});
      end
   endtask

   task automatic test_gt_early();
      int n;
      i_A = 8'hC0; i_B = 8'h3F; i_start = 1'b1;
      step();
      i_start = 1'b0;
      total++;
      if ({o_busy, o_done} !== 2'b10) begin
         bad++;
         $display("FAIL gt_busy got=%b want=10", {o_busy, o_done});
      end
      n = 1;
      while (!o_done && n < 12) begin step(); n++; end
      total++;
      if (n !== 2) begin
         bad++;
         $display("FAIL gt_latency got=%0d want=2", n);
      end
      total++;
      if ({o_GT, o_LT, o_EQ} !== 3'b100) begin
         bad++;
         $display("FAIL gt_flags got=%b want=100", {o_GT, o_LT, o_EQ});
      end
      step();
      total++;
      if ({o_busy, o_done, o_GT} !== 3'b001) begin
         bad++;
         $display("FAIL gt_after_done got=%b want=001", {o_busy, o_done, o_GT});
      end
   endtask

   task automatic test_lt_late();
      int n;
      i_A = 8'hB4; i_B = 8'hB6; i_start = 1'b1;
      step();
      i_start = 1'b0;
      n = 1;
      while (!o_done && n < 12) begin step(); n++; end
      total++;
      if (n !== 5) begin
         bad++;
         $display("FAIL lt_latency got=%0d want=5", n);
      end
      total++;
      if ({o_GT, o_LT, o_EQ} !== 3'b010) begin
         bad++;
         $display("FAIL lt_flags got=%b want=010", {o_GT, o_LT, o_EQ});
      end
      step();
   endtask

   task automatic test_eq_hold();
      int n;
      i_A = 8'h5A; i_B = 8'h5A; i_start = 1'b1;
      step();
      i_start = 1'b0;
      n = 1;
      while (!o_done && n < 12) begin step(); n++; end
      total++;
      if (n !== 5) begin
         bad++;
         $display("FAIL eq_latency got=%0d want=5", n);
      end
      total++;
      if ({o_GT, o_LT, o_EQ} !== 3'b001) begin
         bad++;
         $display("FAIL eq_flags got=%b want=001", {o_GT, o_LT, o_EQ});
      end
      step(); step(); step();
      total++;
      if ({o_busy, o_done, o_GT, o_LT, o_EQ} !== 5'b00001) begin
         bad++;
         $display("FAIL eq_hold got=%b want=00001", {o_busy, o_done, o_GT, o_LT, o_EQ});
      end
   endtask

   task automatic test_start_while_busy();
      int n;
      i_A = 8'h01; i_B = 8'h02; i_start = 1'b1;
      step();
      i_start = 1'b1; i_A = 8'hFF; i_B = 8'h00;
      step();
      i_start = 1'b0;
      n = 2;
      while (!o_done && n < 12) begin step(); n++; end
      total++;
      if (n !== 5) begin
         bad++;
         $display("FAIL busy_latency got=%0d want=5", n);
      end
      total++;
      if ({o_GT, o_LT, o_EQ} !== 3'b010) begin
         bad++;
         $display("FAIL busy_flags got=%b want=010", {o_GT, o_LT, o_EQ});
      end
      // start held high from DONE: one idle cycle, then accepted
      i_A = 8'h80; i_B = 8'h7F; i_start = 1'b1;
      step();
      total++;
      if (o_busy !== 1'b0) begin
         bad++;
         $display("FAIL held_idle got=%b want=0", o_busy);
      end
      step();
      total++;
      if ({o_busy, o_GT, o_LT, o_EQ} !== 4'b1000) begin
         bad++;
         $display("FAIL held_accept got=%b want=1000", {o_busy, o_GT, o_LT, o_EQ});
      end
      i_start = 1'b0;
      step();
      total++;
      if ({o_done, o_GT} !== 2'b11) begin
         bad++;
         $display("FAIL held_result got=%b want=11", {o_done, o_GT});
      end
      step();
   endtask

   task automatic test_reset_mid();
      int n;
      i_A = 8'h10; i_B = 8'h11; i_start = 1'b1;
      step();
      i_start = 1'b0; i_rst = 1'b1;
      step();
      i_rst = 1'b0;
      total++;
      if ({o_busy, o_done, o_GT, o_LT, o_EQ} !== 5'b00000) begin
         bad++;
         $display("FAIL midrst_outputs got=%b want=00000", {o_busy, o_done, o_GT, o_LT, o_EQ});
      end
      step();
      total++;
      if ({o_busy, o_done} !== 2'b00) begin
         bad++;
         $display("FAIL midrst_stays_idle got=%b want=00", {o_busy, o_done});
      end
      i_A = 8'h80; i_B = 8'h7F; i_start = 1'b1;
      step();
      i_start = 1'b0;
      n = 1;
      while (!o_done && n < 12) begin step(); n++; end
      total++;
      if (n !== 2 || {o_GT, o_LT, o_EQ} !== 3'b100) begin
         bad++;
         $display("FAIL midrst_recover got=lat%0d/%b want=lat2/100", n, {o_GT, o_LT, o_EQ});
      end
      // reset during the DONE cycle also clears everything
      i_rst = 1'b1;
      step();
      i_rst = 1'b0;
      total++;
      if ({o_busy, o_done, o_GT, o_LT, o_EQ} !== 5'b00000) begin
         bad++;
         $display("FAIL donerst_outputs got=%b want=00000", {o_busy, o_done, o_GT, o_LT, o_EQ});
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] av, bv;
      logic [2:0] expf;
      int k, n;
      for (int a = 0; a < 256; a++) begin
         for (int j = 0; j < 6; j++) begin
            av = 8'(a);
            case (j)
               0: bv = av;
               1: bv = av ^ 8'h01;
               2: bv = av ^ 8'h40;
               3: bv = av ^ 8'h10;
               4: bv = av ^ 8'h04;
               default: bv = 8'(a * 37 + 11);
            endcase
            expf = (av > bv) ? 3'b100 : ((av < bv) ? 3'b010 : 3'b001);
            k = 4;
            for (int d = 3; d >= 0; d--) begin
               if (av[2*d +: 2] != bv[2*d +: 2]) begin
                  k = 4 - d;
                  break;
               end
            end
            i_A = av; i_B = bv; i_start = 1'b1;
            if (o_busy) step();
            step();
            i_start = 1'b0;
            n = 1;
            while (!o_done && n < 12) begin step(); n++; end
            total++;
            if (n !== k + 1) begin
               bad++;
               $display("FAIL sweep_latency A=%h B=%h got=%0d want=%0d", av, bv, n, k + 1);
            end
            total++;
            if ({o_GT, o_LT, o_EQ} !== expf) begin
               bad++;
               $display("FAIL sweep_flags A=%h B=%h got=%b want=%b", av, bv, {o_GT, o_LT, o_EQ}, expf);
            end
         end
      end
      step();
   endtask

   initial begin
      test_reset();
      test_gt_early();
      test_lt_late();
      test_eq_hold();
      test_start_while_busy();
      test_reset_mid();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
